keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad, the input-side counterpart of the display multiplexer.
- Drives columns one at a time, samples rows, debounces, and decodes the key.
- Accumulates decimal digits into the 8-bit operand N consumed by the datapath.
- The '#' key issues a one-cycle Start pulse to the control FSM.

Parameters:
- SCAN_DIV, 50000: Clk cycles each column stays driven (one "slot").
- DEBOUNCE_SLOTS, 4: consecutive slots a condition must hold to count as stable. Applies to both press and release.

Ports:
- Clk  input  1  system clock
- Rst  input  1  asynchronous, active-high reset
- Filas  input  4  keypad rows, active-low, externally pulled up
- Columnas  output  4  keypad column drive, one-hot active-low
- N  output  8  accumulated operand, binary 0..255
- Start  output  1  one-Clk pulse when '#' is accepted
- Tecla_valida  output  1  one-Clk pulse on every accepted key press
- Codigo  output  4  code of the last accepted key; held between presses

Behaviour:
- Reset values (asynchronous, active-high):
  - Columnas=4'b1110 (column 0 driven); N=0, Start=0, Tecla_valida=0, Codigo=0.
  - State=SCAN; slot counter and debounce counter = 0.
  - Rst mid-operation (including mid-debounce or while a key is held) returns to these values immediately.
- Filas passes through a 2-FF synchronizer before any use.
- Slot timing:
  - Slot counter runs 0..SCAN_DIV-1.
  - Rows are evaluated only on the cycle the counter equals SCAN_DIV-1 (the "slot end").
- Row priority: if several rows are low, the lowest-index low row wins.
- SCAN state:
  - At slot end with all rows high: rotate Columnas left by one (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - At slot end with any row low: latch (column, row), go to DEBOUNCE with count=1, and stop rotating.
- DEBOUNCE state:
  - At each slot end, same row low: count++.
  - Different row or all rows high: return to SCAN, advance column.
  - When count reaches DEBOUNCE_SLOTS: accept the key and go to RELEASE.
  - With DEBOUNCE_SLOTS=1, the key is accepted at the first detection slot end.
- Key acceptance:
  - Tecla_valida pulses for exactly 1 cycle.
  - Codigo is updated in that same cycle.
  - The action below takes effect on the next Clk edge.
- RELEASE state:
  - Needs DEBOUNCE_SLOTS consecutive slot ends with all rows high, then go to SCAN and advance column.
  - Any low row restarts the release count.
  - A held key never repeats.
- Key map (row r, column c):
  - Row 0: 1 2 3 A. Row 1: 4 5 6 B. Row 2: 7 8 9 C. Row 3: * 0 # D.
  - Codigo: digits 0..9 -> value; A..D -> 10..13; * -> 14; # -> 15.
- Actions on acceptance:
  - Digit d: compute t = N*10 + d in 12-bit unsigned. If t <= 255, N=t; otherwise N is unchanged (digit ignored, no saturation).
  - * : N=0.
  - # : Start=1 for one cycle; N unchanged.
  - A..D: Codigo and Tecla_valida only; no change to N.
- Start and Tecla_valida are never asserted outside acceptance cycles.
- Start coincides with the Tecla_valida pulse for '#'.

Decomposition:
- Shared package holds:
  - key-code constants: KEY_CLEAR=14, KEY_ENTER=15, KEY_A..KEY_D;
  - state encoding: SCAN, DEBOUNCE, RELEASE;
  - column rotation reset value 4'b1110.
- One natural sub-module: keypad_decode. It is combinational and maps (column index, row index) to the 4-bit Codigo.
- Synchronizer, timers, FSM and accumulator stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_SLOTS=2):
- Reset, no keys pressed -> Columnas cycles 1110, 1101, 1011, 0111, 1110, changing every 4 Clk. N=0, Start=0.
- Press '1', '2', '3' in turn, each held ≥3 slots then released ≥3 slots -> 3 Tecla_valida pulses; Codigo 1, 2, 3; N=1, 12, 123.
- With N=123, press '9' -> Tecla_valida pulses, Codigo=9, N stays 123 (1239 > 255). Then '*' -> N=0, Codigo=14.
- With N=255, press '#' -> exactly one Start pulse coincident with Tecla_valida. Codigo=15, N=255. Hold '#' 20 slots -> no further pulses.
- Bounce: assert row 1 for 1 slot, release, reassert -> no acceptance until 2 consecutive stable slots. Two simultaneous rows in one column -> the lower row's key is accepted.
- Assert Rst while '5' is in DEBOUNCE with N=42 -> outputs return to reset values immediately. After release of Rst, keypad scan restarts at column 0.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared constants, state encoding and small helpers for the keypad scanner.
package keypad_scanner_pkg;

    // Key codes for the non-digit keys
    localparam logic [3:0] KEY_A     = 4'd10;
    localparam logic [3:0] KEY_B     = 4'd11;
    localparam logic [3:0] KEY_C     = 4'd12;
    localparam logic [3:0] KEY_D     = 4'd13;
    localparam logic [3:0] KEY_CLEAR = 4'd14;
    localparam logic [3:0] KEY_ENTER = 4'd15;

    // Column drive after reset: column 0 pulled low
    localparam logic [3:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } state_e;

    // Index of the driven (low) column in a one-hot active-low drive word
    function automatic logic [1:0] col_index(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Lowest-index low row wins when several rows are pulled low
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_decode.sv
// Combinational key map: (column, row) of the matrix to the 4-bit key code.
module keypad_scanner_decode
    import keypad_scanner_pkg::*;
(
    input  logic [1:0] col_i,
    input  logic [1:0] row_i,
    output logic [3:0] code_o
);

    // Rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    always_comb begin
        code_o = 4'd0;
        unique case ({row_i, col_i})
            4'b00_00: code_o = 4'd1;
            4'b00_01: code_o = 4'd2;
            4'b00_10: code_o = 4'd3;
            4'b00_11: code_o = KEY_A;
            4'b01_00: code_o = 4'd4;
            4'b01_01: code_o = 4'd5;
            4'b01_10: code_o = 4'd6;
            4'b01_11: code_o = KEY_B;
            4'b10_00: code_o = 4'd7;
            4'b10_01: code_o = 4'd8;
            4'b10_10: code_o = 4'd9;
            4'b10_11: code_o = KEY_C;
            4'b11_00: code_o = KEY_CLEAR;
            4'b11_01: code_o = 4'd0;
            4'b11_10: code_o = KEY_ENTER;
            4'b11_11: code_o = KEY_D;
            default:  code_o = 4'd0;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row debounce, key decode and
// decimal accumulation into the operand N. '#' issues a one-cycle Start.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SLOTS = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Filas,
    output logic [3:0] Columnas,
    output logic [7:0] N,
    output logic       Start,
    output logic       Tecla_valida,
    output logic [3:0] Codigo
);

    localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DebW  = $clog2(DEBOUNCE_SLOTS + 1);
    localparam logic [SlotW-1:0] SlotLast  = SlotW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0]  DebTarget = DebW'(DEBOUNCE_SLOTS);

    logic [3:0]       filas_meta_q, filas_sync_q;
    logic [SlotW-1:0] slot_q;
    logic             slot_end;
    state_e           state_q, state_d;
    logic [3:0]       cols_q, cols_d;
    logic [DebW-1:0]  deb_q, deb_d, deb_inc;
    logic [1:0]       row_lat_q, row_lat_d;
    logic             any_low;
    logic [1:0]       row_now;
    logic             accept;
    logic [3:0]       key_code;
    logic             tecla_q, start_q;
    logic [3:0]       codigo_q;
    logic [7:0]       n_q, n_d;
    logic [11:0]      n_times_ten;

    // Two-flop synchronizer on the asynchronous row inputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            filas_meta_q <= 4'hF;
            filas_sync_q <= 4'hF;
        end else begin
            filas_meta_q <= Filas;
            filas_sync_q <= filas_meta_q;
        end
    end

    // Slot timer: rows are only looked at on the last cycle of each slot
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            slot_q <= '0;
        end else if (slot_end) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_q + SlotW'(1);
        end
    end

    assign slot_end = (slot_q == SlotLast);
    assign any_low  = ~&filas_sync_q;
    assign row_now  = lowest_low_row(filas_sync_q);
    assign deb_inc  = deb_q + DebW'(1);

    keypad_scanner_decode u_decode (
        .col_i  (col_index(cols_q)),
        .row_i  (row_now),
        .code_o (key_code)
    );

    // Scan FSM state, column drive, debounce count and latched row
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= SCAN;
            cols_q    <= COL_RESET;
            deb_q     <= '0;
            row_lat_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            cols_q    <= cols_d;
            deb_q     <= deb_d;
            row_lat_q <= row_lat_d;
        end
    end

    // Next-state: rotate while idle, count stable slots on press and release
    always_comb begin
        state_d   = state_q;
        cols_d    = cols_q;
        deb_d     = deb_q;
        row_lat_d = row_lat_q;
        accept    = 1'b0;
        if (slot_end) begin
            unique case (state_q)
                SCAN: begin
                    if (any_low) begin
                        row_lat_d = row_now;
                        if (DEBOUNCE_SLOTS <= 1) begin
                            accept  = 1'b1;
                            state_d = RELEASE;
                            deb_d   = '0;
                        end else begin
                            state_d = DEBOUNCE;
                            deb_d   = DebW'(1);
                        end
                    end else begin
                        cols_d = {cols_q[2:0], cols_q[3]};
                    end
                end
                DEBOUNCE: begin
                    if (any_low && (row_now == row_lat_q)) begin
                        if (deb_inc >= DebTarget) begin
                            accept  = 1'b1;
                            state_d = RELEASE;
                            deb_d   = '0;
                        end else begin
                            deb_d = deb_inc;
                        end
                    end else begin
                        state_d = SCAN;
                        cols_d  = {cols_q[2:0], cols_q[3]};
                        deb_d   = '0;
                    end
                end
                RELEASE: begin
                    if (any_low) begin
                        deb_d = '0;
                    end else if (deb_inc >= DebTarget) begin
                        state_d = SCAN;
                        cols_d  = {cols_q[2:0], cols_q[3]};
                        deb_d   = '0;
                    end else begin
                        deb_d = deb_inc;
                    end
                end
                default: begin
                    state_d = SCAN;
                    deb_d   = '0;
                end
            endcase
        end
    end

    // Acceptance pulses and the held key code
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tecla_q  <= 1'b0;
            start_q  <= 1'b0;
            codigo_q <= 4'd0;
        end else begin
            tecla_q <= accept;
            start_q <= accept && (key_code == KEY_ENTER);
            if (accept) codigo_q <= key_code;
        end
    end

    // Operand register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            n_q <= 8'd0;
        end else begin
            n_q <= n_d;
        end
    end

    // Key action lands the cycle after the pulse; overflowing digits are dropped
    always_comb begin
        n_d         = n_q;
        n_times_ten = ({4'd0, n_q} * 12'd10) + {8'd0, codigo_q};
        if (tecla_q) begin
            if (codigo_q <= 4'd9) begin
                if (n_times_ten <= 12'd255) n_d = n_times_ten[7:0];
            end else if (codigo_q == KEY_CLEAR) begin
                n_d = 8'd0;
            end
        end
    end

    assign Columnas     = cols_q;
    assign N            = n_q;
    assign Start        = start_q;
    assign Tecla_valida = tecla_q;
    assign Codigo       = codigo_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives Filas from the
// pressed-key matrix and Columnas; presses push expected responses.
module tb_keypad_scanner;

    localparam int unsigned ScanDiv = 4;
    localparam int unsigned DebSlots = 2;
    localparam int unsigned Slot = ScanDiv;

    logic       Clk;
    logic       Rst;
    logic [3:0] Filas;
    logic [3:0] Columnas;
    logic [7:0] N;
    logic       Start;
    logic       Tecla_valida;
    logic [3:0] Codigo;

    logic [15:0] key_mat;

    typedef struct {
        logic [3:0] code;
        logic       start;
        logic [7:0] n;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    keypad_scanner #(
        .SCAN_DIV       (ScanDiv),
        .DEBOUNCE_SLOTS (DebSlots)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Filas        (Filas),
        .Columnas     (Columnas),
        .N            (N),
        .Start        (Start),
        .Tecla_valida (Tecla_valida),
        .Codigo       (Codigo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Keypad model: a held key shorts its row low while its column is driven
    always_comb begin
        Filas = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mat[r*4+c] && !Columnas[c]) Filas[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_key(input logic [3:0] code, input logic start, input logic [7:0] n);
        exp_t e;
        e.code  = code;
        e.start = start;
        e.n     = n;
        exp_q.push_back(e);
    endtask

    // Press key (r,c), hold, release and let the release debounce finish
    task automatic press(input int r, input int c, input int hold_slots);
        key_mat[r*4+c] = 1'b1;
        repeat (hold_slots * Slot) @(negedge Clk);
        key_mat = '0;
        repeat (4 * Slot) @(negedge Clk);
    endtask

    task automatic wait_col(input logic [3:0] target);
        logic [3:0] prev;
        bit         seen;
        prev = Columnas;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge Clk);
            if (Columnas == target && prev != target) seen = 1'b1;
            prev = Columnas;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_col: column %b never became driven", target);
        end
    endtask

    // Monitor: every pulse must match the head of the expectation queue
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                if (Start && !Tecla_valida) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL start_alone: Start=1 while Tecla_valida=0");
                end
                if (Tecla_valida) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_key: pulse with Codigo=%0d, none expected",
                                 Codigo);
                    end else begin
                        e = exp_q.pop_front();
                        check("codigo", 32'(Codigo), 32'(e.code));
                        check("start", 32'(Start), 32'(e.start));
                        @(negedge Clk);
                        check("pulse_width", 32'(Tecla_valida), 32'd0);
                        check("operand_n", 32'(N), 32'(e.n));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        key_mat  = '0;
        Rst      = 1'b1;
        repeat (3) @(negedge Clk);

        check("rst_columnas", 32'(Columnas), 32'h0E);
        check("rst_n", 32'(N), 32'd0);
        check("rst_start", 32'(Start), 32'd0);
        check("rst_tecla", 32'(Tecla_valida), 32'd0);
        check("rst_codigo", 32'(Codigo), 32'd0);

        // Idle rotation: column changes every ScanDiv cycles
        Rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] exp_col;
            exp_col = 4'hF;
            exp_col[(k / 4) % 4] = 1'b0;
            check("idle_rotation", 32'(Columnas), 32'(exp_col));
            check("idle_start", 32'(Start), 32'd0);
            @(negedge Clk);
        end
        check("idle_n", 32'(N), 32'd0);

        // Accumulate 1, 12, 123; overflow digit ignored; clear
        expect_key(4'd1, 1'b0, 8'd1);    press(0, 0, 8);
        expect_key(4'd2, 1'b0, 8'd12);   press(0, 1, 8);
        expect_key(4'd3, 1'b0, 8'd123);  press(0, 2, 8);
        expect_key(4'd9, 1'b0, 8'd123);  press(2, 2, 8);
        expect_key(4'd14, 1'b0, 8'd0);   press(3, 0, 8);

        // Build 255 then hold '#' for 20 slots: single Start
        expect_key(4'd2, 1'b0, 8'd2);    press(0, 1, 8);
        expect_key(4'd5, 1'b0, 8'd25);   press(1, 1, 8);
        expect_key(4'd5, 1'b0, 8'd255);  press(1, 1, 8);
        expect_key(4'd15, 1'b1, 8'd255); press(3, 2, 20);
        expect_key(4'd10, 1'b0, 8'd255); press(0, 3, 8);
        expect_key(4'd6, 1'b0, 8'd255);  press(1, 2, 8);
        expect_key(4'd13, 1'b0, 8'd255); press(3, 3, 8);
        expect_key(4'd14, 1'b0, 8'd0);   press(3, 0, 8);

        // Bounce: '4' low for exactly one slot end, then released
        wait_col(4'b1110);
        key_mat[1*4+0] = 1'b1;
        repeat (Slot) @(negedge Clk);
        key_mat = '0;
        repeat (6 * Slot) @(negedge Clk);
        check("bounce_no_key", 32'(exp_q.size()), 32'd0);
        expect_key(4'd4, 1'b0, 8'd4);    press(1, 0, 8);

        // Two rows in column 1: row 0 ('2') beats row 2 ('8')
        key_mat[2*4+1] = 1'b1;
        expect_key(4'd2, 1'b0, 8'd42);   press(0, 1, 8);

        // Reset while '5' is mid-debounce
        wait_col(4'b1110);
        key_mat[1*4+1] = 1'b1;
        wait_col(4'b1101);
        repeat (5) @(negedge Clk);
        check("pre_rst_n", 32'(N), 32'd42);
        Rst = 1'b1;
        #1;
        check("midrst_columnas", 32'(Columnas), 32'h0E);
        check("midrst_n", 32'(N), 32'd0);
        check("midrst_start", 32'(Start), 32'd0);
        check("midrst_tecla", 32'(Tecla_valida), 32'd0);
        check("midrst_codigo", 32'(Codigo), 32'd0);
        repeat (2) @(negedge Clk);
        key_mat = '0;
        Rst = 1'b0;
        check("restart_col0", 32'(Columnas), 32'h0E);
        repeat (4) @(negedge Clk);
        check("restart_col1", 32'(Columnas), 32'h0D);
        repeat (8 * Slot) @(negedge Clk);
        check("post_rst_n", 32'(N), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
